// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage:
//   - bus widths for the EX->MEM and MEM->WB buses
//   - load_op encodings
//   - packed structs giving named access to the bus fields
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 107;
   localparam int MS_TO_WS_BUS_WD = 71;

   // Code 7 is reserved and behaves as LW.
   typedef enum logic [2:0] {
      LOAD_LW  = 3'd0,
      LOAD_LB  = 3'd1,
      LOAD_LBU = 3'd2,
      LOAD_LH  = 3'd3,
      LOAD_LHU = 3'd4,
      LOAD_LWL = 3'd5,
      LOAD_LWR = 3'd6,
      LOAD_RSV = 3'd7
   } load_op_e;

   // Field order is MSB first and matches the flat EX->MEM bus.
   typedef struct packed {
      logic        ex;
      logic        res_from_mem;
      load_op_e    load_op;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] rt_value;
      logic [31:0] result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        ex;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// mem_stage_load_align
// Purely combinational load data alignment / extension.
// Ports:
//   load_op_i  : load_op code of the instruction
//   addr_i     : low two bits of the load address
//   rdata_i    : raw 32-bit word returned by the data SRAM
//   rt_value_i : old rt value, merged in by LWL/LWR
//   aligned_o  : register write value for the load
// -----------------------------------------------------------------------------
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  load_op_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] rt_value_i,
   output logic [31:0] aligned_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Byte lane a sits at bits [8a+7:8a]; shift it down to bit 0.
   assign shifted = rdata_i >> {addr_i, 3'b000};
   assign byte_v  = shifted[7:0];
   assign half_v  = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      aligned_o = rdata_i;
      case (load_op_e'(load_op_i))
         LOAD_LB:  aligned_o = {{24{byte_v[7]}}, byte_v};
         LOAD_LBU: aligned_o = {24'h0, byte_v};
         LOAD_LH:  aligned_o = {{16{half_v[15]}}, half_v};
         LOAD_LHU: aligned_o = {16'h0, half_v};
         LOAD_LWL: begin
            case (addr_i)
               2'd0:    aligned_o = {rdata_i[7:0],  rt_value_i[23:0]};
               2'd1:    aligned_o = {rdata_i[15:0], rt_value_i[15:0]};
               2'd2:    aligned_o = {rdata_i[23:0], rt_value_i[7:0]};
               default: aligned_o = rdata_i;
            endcase
         end
         LOAD_LWR: begin
            case (addr_i)
               2'd0:    aligned_o = rdata_i;
               2'd1:    aligned_o = {rt_value_i[31:24], rdata_i[31:8]};
               2'd2:    aligned_o = {rt_value_i[31:16], rdata_i[31:16]};
               default: aligned_o = {rt_value_i[31:8],  rdata_i[31:24]};
            endcase
         end
         default:  aligned_o = rdata_i;  // LW and reserved code
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage between EX and WB. Holds one instruction,
// waits for the data-SRAM read response of loads, aligns the data and
// presents the MEM->WB bus. Also drives MEM forwarding to ID and discards
// responses that belong to flushed loads.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ws_allowin          : WB can accept this cycle
//   ms_allowin          : MEM can accept this cycle
//   es_to_ms_valid/bus  : instruction from EX (107 bits)
//   ms_to_ws_valid/bus  : instruction to WB (71 bits)
//   flush               : exception/eret flush, kills the MEM instruction
//   data_sram_data_ok   : one response strobe per request issued by EX
//   data_sram_rdata     : response data
//   MEM_dest/MEM_result : forwarding destination / value
//   MEM_load_pending    : valid load still waiting on its data
//
// Handshake: a stage transfers on a cycle where its valid and the
// receiver's allowin are both high. valid never depends on the receiver's
// allowin; ms_allowin is high when MEM is empty or its instruction leaves
// this cycle.
// -----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       flush,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic [4:0]                 MEM_dest,
   output logic [31:0]                MEM_result,
   output logic                       MEM_load_pending
);

   logic        ms_valid_q;
   es_to_ms_t   ms_bus_q;
   logic        buf_valid_q;
   logic [31:0] buf_data_q;
   logic [1:0]  cancel_cnt_q;
   logic [1:0]  cancel_cnt_d;

   logic        ms_ready_go;
   logic        is_load;
   logic        data_ok_cur;
   logic        cnt_inc;
   logic        cnt_dec;
   logic        ms_leave;
   logic [31:0] load_data;
   logic [31:0] aligned;
   logic [31:0] final_result;
   ms_to_ws_t   ws_bus;

   // A load that actually waits for memory (exceptional loads do not).
   assign is_load     = ms_bus_q.res_from_mem && !ms_bus_q.ex;
   // A response belongs to the current load only when no stale responses
   // from flushed loads are still outstanding.
   assign data_ok_cur = data_sram_data_ok && (cancel_cnt_q == 2'd0);

   assign ms_ready_go    = !is_load || buf_valid_q || data_ok_cur;
   assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
   assign ms_leave       = ms_to_ws_valid && ws_allowin;

   assign load_data = buf_valid_q ? buf_data_q : data_sram_rdata;

   mem_stage_load_align u_align (
      .load_op_i  (ms_bus_q.load_op),
      .addr_i     (ms_bus_q.result[1:0]),
      .rdata_i    (load_data),
      .rt_value_i (ms_bus_q.rt_value),
      .aligned_o  (aligned)
   );

   assign final_result = ms_bus_q.res_from_mem ? aligned : ms_bus_q.result;

   always_comb begin
      ws_bus              = '0;
      ws_bus.ex           = ms_bus_q.ex;
      ws_bus.gr_we        = ms_bus_q.gr_we;
      ws_bus.dest         = ms_bus_q.dest;
      ws_bus.final_result = final_result;
      ws_bus.pc           = ms_bus_q.pc;
   end
   assign ms_to_ws_bus = ws_bus;

   assign MEM_dest         = ms_bus_q.dest & {5{ms_valid_q && ms_bus_q.gr_we && !ms_bus_q.ex}};
   assign MEM_result       = final_result;
   assign MEM_load_pending = ms_valid_q && is_load && !ms_ready_go;

   // Flushing a load whose response is still in flight leaves one stale
   // response to swallow later. A same-cycle response is simply consumed.
   assign cnt_inc = flush && ms_valid_q && is_load && !buf_valid_q && !data_ok_cur;
   assign cnt_dec = data_sram_data_ok && (cancel_cnt_q != 2'd0);

   always_comb begin
      cancel_cnt_d = cancel_cnt_q;
      if (cnt_inc && !cnt_dec && (cancel_cnt_q != 2'd3)) begin
         cancel_cnt_d = cancel_cnt_q + 2'd1;
      end else if (cnt_dec && !cnt_inc) begin
         cancel_cnt_d = cancel_cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_q   <= 1'b0;
         ms_bus_q     <= '0;
         buf_valid_q  <= 1'b0;
         buf_data_q   <= 32'h0;
         cancel_cnt_q <= 2'd0;
      end else begin
         cancel_cnt_q <= cancel_cnt_d;

         if (flush) begin
            ms_valid_q <= 1'b0;
         end else if (ms_allowin) begin
            ms_valid_q <= es_to_ms_valid;
         end

         if (es_to_ms_valid && ms_allowin) begin
            ms_bus_q <= es_to_ms_t'(es_to_ms_bus);
         end

         // Hold the response when WB stalls so it is not lost.
         if (flush || ms_leave) begin
            buf_valid_q <= 1'b0;
         end else if (ms_valid_q && is_load && !buf_valid_q && data_ok_cur && !ws_allowin) begin
            buf_valid_q <= 1'b1;
            buf_data_q  <= data_sram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage: ALU pass-through, load alignment cases,
// WB back-pressure with buffered load data, flushed-load response discard,
// exceptional load and reset while a load is waiting.
// -----------------------------------------------------------------------------
module tb_mem_stage;
   import mem_stage_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                       reset;
   logic                       ws_allowin;
   logic                       ms_allowin;
   logic                       es_to_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
   logic                       ms_to_ws_valid;
   logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
   logic                       flush;
   logic                       data_sram_data_ok;
   logic [31:0]                data_sram_rdata;
   logic [4:0]                 MEM_dest;
   logic [31:0]                MEM_result;
   logic                       MEM_load_pending;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ws_allowin        (ws_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .flush             (flush),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .MEM_dest          (MEM_dest),
      .MEM_result        (MEM_result),
      .MEM_load_pending  (MEM_load_pending)
   );

   int checks   = 0;
   int failures = 0;
   int xfers    = 0;
   logic [MS_TO_WS_BUS_WD-1:0] exp_q[$];

   task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [106:0] es_bus(input logic ex, input logic rfm, input logic [2:0] lop,
                                           input logic gwe, input logic [4:0] dest,
                                           input logic [31:0] rt, input logic [31:0] res,
                                           input logic [31:0] pc);
      return {ex, rfm, lop, gwe, dest, rt, res, pc};
   endfunction

   function automatic logic [70:0] ws_bus(input logic ex, input logic gwe, input logic [4:0] dest,
                                          input logic [31:0] fr, input logic [31:0] pc);
      return {ex, gwe, dest, fr, pc};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!reset && ms_to_ws_valid && ws_allowin) begin
         xfers++;
         if (exp_q.size() == 0) check("unexpected_xfer", 71'(1), 71'(0));
         else                   check("wb_bus", ms_to_ws_bus, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction; returns 1 time unit after the accepting edge.
   task automatic send(input logic [106:0] bus);
      int n;
      n = 0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = bus;
      @(negedge clk);
      while (!ms_allowin && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ms_allowin) check("send_timeout", 71'(ms_allowin), 71'(1));
      step();
      es_to_ms_valid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [2:0] lop, input logic [1:0] a,
                          input logic [31:0] rd, input logic [31:0] rt, input logic [31:0] exp_v);
      logic [31:0] pc;
      pc = 32'hBFC0_0100;
      send(es_bus(1'b0, 1'b1, lop, 1'b1, 5'd7, rt, 32'h1000_0000 | 32'(a), pc));
      @(negedge clk);
      check({tag, "_pending"}, 71'(MEM_load_pending), 71'(1));
      check({tag, "_wait_valid"}, 71'(ms_to_ws_valid), 71'(0));
      step();
      exp_q.push_back(ws_bus(1'b0, 1'b1, 5'd7, exp_v, pc));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rd;
      @(negedge clk);
      check({tag, "_result"}, 71'(MEM_result), 71'(exp_v));
      check({tag, "_pending_off"}, 71'(MEM_load_pending), 71'(0));
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int x0;
      reset             = 1'b1;
      ws_allowin        = 1'b1;
      es_to_ms_valid    = 1'b0;
      es_to_ms_bus      = '0;
      flush             = 1'b0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
      repeat (2) step();

      @(negedge clk);
      check("rst_valid", 71'(ms_to_ws_valid), 71'(0));
      check("rst_dest", 71'(MEM_dest), 71'(0));
      check("rst_pending", 71'(MEM_load_pending), 71'(0));
      check("rst_allowin", 71'(ms_allowin), 71'(1));
      check("rst_bus", ms_to_ws_bus, 71'(0));
      step();
      reset = 1'b0;

      // ALU op: visible to WB in the cycle after acceptance.
      exp_q.push_back(ws_bus(1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'hBFC0_0000));
      send(es_bus(1'b0, 1'b0, 3'd0, 1'b1, 5'd5, 32'h0, 32'h1234_5678, 32'hBFC0_0000));
      @(negedge clk);
      check("alu_valid", 71'(ms_to_ws_valid), 71'(1));
      check("alu_dest", 71'(MEM_dest), 71'(5));
      check("alu_result", 71'(MEM_result), 71'(32'h1234_5678));
      step();

      // Alignment cases.
      do_load("lb_a3",  3'd1, 2'd3, 32'h80FF_FF12, 32'h0,         32'hFFFF_FF80);
      do_load("lbu_a3", 3'd2, 2'd3, 32'h80FF_FF12, 32'h0,         32'h0000_0080);
      do_load("lh_a2",  3'd3, 2'd2, 32'h80FF_FF12, 32'h0,         32'hFFFF_80FF);
      do_load("lhu_a0", 3'd4, 2'd0, 32'h1234_F00D, 32'h0,         32'h0000_F00D);
      do_load("lwl_a1", 3'd5, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'h3344_CCDD);
      do_load("lwr_a1", 3'd6, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hAA11_2233);
      do_load("lwl_a0", 3'd5, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'h44BB_CCDD);
      do_load("lwr_a3", 3'd6, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CC11);
      do_load("lw",     3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF);
      do_load("rsv",    3'd7, 2'd0, 32'h0BAD_F00D, 32'h0,         32'h0BAD_F00D);

      // WB stalled while the response arrives: data must be buffered.
      ws_allowin = 1'b0;
      send(es_bus(1'b0, 1'b1, 3'd0, 1'b1, 5'd3, 32'h0, 32'h2000_0000, 32'hBFC0_0200));
      @(negedge clk);
      check("buf_pending", 71'(MEM_load_pending), 71'(1));
      step();
      exp_q.push_back(ws_bus(1'b0, 1'b1, 5'd3, 32'hCAFE_F00D, 32'hBFC0_0200));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hCAFE_F00D;
      @(negedge clk);
      check("buf_pending_off", 71'(MEM_load_pending), 71'(0));
      check("buf_valid_out", 71'(ms_to_ws_valid), 71'(1));
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("buf_hold_result", 71'(MEM_result), 71'(32'hCAFE_F00D));
         check("buf_hold_pending", 71'(MEM_load_pending), 71'(0));
         check("buf_hold_flag", 71'(dut.buf_valid_q), 71'(1));
         step();
      end
      x0 = xfers;
      ws_allowin = 1'b1;
      step();
      @(negedge clk);
      check("buf_drained", 71'(ms_to_ws_valid), 71'(0));
      check("buf_one_xfer", 71'(xfers - x0), 71'(1));
      check("buf_cleared", 71'(dut.buf_valid_q), 71'(0));
      step();

      // Flush a waiting load; its response must be discarded.
      send(es_bus(1'b0, 1'b1, 3'd0, 1'b1, 5'd4, 32'h0, 32'h3000_0000, 32'hBFC0_0300));
      flush = 1'b1;
      @(negedge clk);
      check("flush_valid", 71'(ms_to_ws_valid), 71'(0));
      step();
      flush = 1'b0;
      @(negedge clk);
      check("flush_cnt", 71'(dut.cancel_cnt_q), 71'(1));
      check("flush_dest", 71'(MEM_dest), 71'(0));
      step();
      send(es_bus(1'b0, 1'b1, 3'd0, 1'b1, 5'd9, 32'h0, 32'h3000_0004, 32'hBFC0_0304));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hDEAD_0001;
      @(negedge clk);
      check("stale_valid", 71'(ms_to_ws_valid), 71'(0));
      check("stale_pending", 71'(MEM_load_pending), 71'(1));
      step();
      exp_q.push_back(ws_bus(1'b0, 1'b1, 5'd9, 32'h0000_BEEF, 32'hBFC0_0304));
      data_sram_rdata = 32'h0000_BEEF;
      @(negedge clk);
      check("fresh_valid", 71'(ms_to_ws_valid), 71'(1));
      check("fresh_result", 71'(MEM_result), 71'(32'h0000_BEEF));
      check("fresh_cnt", 71'(dut.cancel_cnt_q), 71'(0));
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;

      // Exceptional load passes at once, no forwarding destination.
      exp_q.push_back(ws_bus(1'b1, 1'b1, 5'd9, 32'h0, 32'hBFC0_0400));
      send(es_bus(1'b1, 1'b1, 3'd0, 1'b1, 5'd9, 32'h0, 32'h4000_0000, 32'hBFC0_0400));
      @(negedge clk);
      check("ex_valid", 71'(ms_to_ws_valid), 71'(1));
      check("ex_dest", 71'(MEM_dest), 71'(0));
      check("ex_pending", 71'(MEM_load_pending), 71'(0));
      step();

      // Reset while a load waits with a stale response outstanding.
      send(es_bus(1'b0, 1'b1, 3'd0, 1'b1, 5'd2, 32'h0, 32'h5000_0000, 32'hBFC0_0500));
      flush = 1'b1;
      step();
      flush = 1'b0;
      send(es_bus(1'b0, 1'b1, 3'd0, 1'b1, 5'd2, 32'h0, 32'h5000_0004, 32'hBFC0_0504));
      @(negedge clk);
      check("pre_rst_pending", 71'(MEM_load_pending), 71'(1));
      step();
      reset = 1'b1;
      step();
      @(negedge clk);
      check("mid_rst_ms_valid", 71'(dut.ms_valid_q), 71'(0));
      check("mid_rst_cnt", 71'(dut.cancel_cnt_q), 71'(0));
      check("mid_rst_buf", 71'(dut.buf_valid_q), 71'(0));
      check("mid_rst_valid", 71'(ms_to_ws_valid), 71'(0));
      check("mid_rst_dest", 71'(MEM_dest), 71'(0));
      check("mid_rst_pending", 71'(MEM_load_pending), 71'(0));
      check("mid_rst_bus", ms_to_ws_bus, 71'(0));
      step();
      reset = 1'b0;
      repeat (2) step();

      // ---------------- final report ----------------
      check("exp_q_drained", 71'(exp_q.size()), 71'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the EX stage and the WB stage.
- Accepts an instruction from EX and, for loads, waits for the data-SRAM read response. It aligns and sign-extends the returned data, then hands a 71-bit bus to WB.
- Provides MEM-stage forwarding and a load-pending stall indication to ID.
- Drops responses that belong to flushed loads.

Parameters:
- ES_TO_MS_BUS_WD, 107, width of the EX→MEM bus.
- MS_TO_WS_BUS_WD, 71, width of the MEM→WB bus.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- ws_allowin  in  1  WB can accept this cycle.
- ms_allowin  out  1  MEM can accept this cycle.
- es_to_ms_valid  in  1  EX bus valid.
- es_to_ms_bus  in  107  fields, MSB first: ex[106], res_from_mem[105], load_op[104:102], gr_we[101], dest[100:96], rt_value[95:64], result[63:32] (ALU result or address), pc[31:0].
- ms_to_ws_valid  out  1  WB bus valid.
- ms_to_ws_bus  out  71  fields: ex[70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0].
- flush  in  1  exception/eret flush; kills the MEM instruction.
- data_sram_data_ok  in  1  read/write response strobe (one per request issued by EX).
- data_sram_rdata  in  32  response data.
- MEM_dest  out  5  forwarding destination register, 0 when not valid.
- MEM_result  out  32  forwarding data.
- MEM_load_pending  out  1  valid load whose data has not yet arrived; ID stalls on a match.

Behaviour:
- Reset values:
  - ms_valid=0; the bus register and data buffer are 0.
  - buf_valid=0, cancel_cnt=0.
  - All outputs derived from these, so ms_to_ws_valid=0, MEM_dest=0, MEM_load_pending=0.
- Handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - On ms_allowin, ms_valid <= es_to_ms_valid && !flush.
  - The bus is latched when es_to_ms_valid && ms_allowin.
  - ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
- ms_ready_go:
  - 1 when !res_from_mem or ex=1; exceptional loads wait for nothing.
  - Otherwise ms_ready_go = buf_valid || (data_ok && cancel_cnt==0).
- Data buffer:
  - Set when data_ok arrives with cancel_cnt==0 for the current load but ws_allowin=0. It captures rdata and sets buf_valid.
  - Cleared when the instruction leaves MEM (ms_to_ws_valid && ws_allowin) or on flush.
  - Latency: 0 cycles from data_ok to ms_to_ws_valid when WB accepts.
- Flush:
  - If the MEM instruction is a non-ex load with no data received yet (no buffer, no same-cycle data_ok), cancel_cnt increments.
  - Each data_ok with cancel_cnt>0 decrements it and is discarded (never buffered, never forwarded).
  - cancel_cnt is 2 bits; saturation never occurs by construction, but the counter holds at 3 and does not wrap.
  - Simultaneous flush and data_ok for the current load: the data is consumed (discarded) and no increment occurs.
- Load alignment (a = result[1:0], d = rdata, rt = rt_value; load_op codes 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 reserved and treated as LW):
  - LB/LBU: byte d[8a+7:8a], sign-extended for LB, zero-extended for LBU.
  - LH/LHU: halfword d[16a[1]+15:16a[1]], sign- or zero-extended.
  - LWL, by a = 0/1/2/3: {d[7:0],rt[23:0]}, {d[15:0],rt[15:0]}, {d[23:0],rt[7:0]}, d.
  - LWR, by a = 0/1/2/3: d, {rt[31:24],d[31:8]}, {rt[31:16],d[31:16]}, {rt[31:8],d[31:24]}.
  - final_result = res_from_mem ? aligned : result.
- Forwarding:
  - MEM_dest = dest & {5{ms_valid && gr_we && !ex}}.
  - MEM_result = final_result.
  - MEM_load_pending = ms_valid && res_from_mem && !ex && !ms_ready_go.
- Stores (res_from_mem=0) pass in 1 cycle. Their data_ok responses are counted by EX, not here.

Decomposition:
- Bus widths ES_TO_MS_BUS_WD and MS_TO_WS_BUS_WD, and the load_op codes, belong as macros in global_defines.vh.
- One natural sub-module: mem_load_align, purely combinational, with inputs load_op, addr[1:0], rdata, rt_value and output aligned[31:0].

Test Plan:
- ALU op, no load, ws_allowin=1 → ms_to_ws_valid in the cycle after acceptance; bus = {0,1,dest,result,pc}.
- LB at a=3 with rdata=0x80FF_FF12 → final_result 0xFFFF_FF80. LBU at a=3 → 0x0000_0080. LH at a=2 → 0xFFFF_80FF.
- LWL at a=1 with rdata=0x1122_3344, rt=0xAABB_CCDD → 0x3344_CCDD. LWR at a=1 → 0xAA11_2233.
- Load, data_ok arrives while ws_allowin=0 for 3 cycles → data buffered; MEM_load_pending=0 after data_ok; exactly one ms_to_ws transfer carries the buffered value.
- Load pending, flush asserted, then a new load enters and two data_ok pulses arrive → first pulse discarded (cancel_cnt 1→0), second delivered to the new load.
- Reset asserted mid-wait → next cycle ms_valid=0, cancel_cnt=0, buf_valid=0, all outputs 0.
